// File: rtl/rs_select_arbiter_pkg.sv
// Shared constants and FSM encoding for the RS issue/allocate arbiter.
package rs_select_arbiter_pkg;

   localparam int RS_SIZE_DEF = 16;
   localparam int RS_BIT_DEF  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } issue_state_t;

endpackage

// File: rtl/rs_prio_pick.sv
// Rotated find-first-set: first set bit of req at or after base, wrapping; purely combinational.
// N must be 2**W so the index arithmetic wraps for free.
module rs_prio_pick #(
   parameter int N = 16,
   parameter int W = 4
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] base,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [W-1:0] pos;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = 0; k < N; k++) begin
         pos = base + W'(k);
         if (!found && req[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/rs_select_arbiter.sv
// RS issue/allocate arbiter: one registered issue pick per cycle held under valid/ready, plus a reserved free slot.
// New eligibility is presented one edge later; rdy_in=0 freezes everything, exe_ready_in=0 holds the current pick.
module rs_select_arbiter
   import rs_select_arbiter_pkg::*;
#(
   parameter int RS_SIZE = RS_SIZE_DEF,
   parameter int RS_BIT  = RS_BIT_DEF,
   parameter int RR_MODE = 1
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              clear_in,
   input  logic [RS_SIZE-1:0] busy_in,
   input  logic [RS_SIZE-1:0] prepared_in,
   input  logic              exe_ready_in,
   input  logic              alloc_req_in,
   output logic              fire_valid_out,
   output logic [RS_BIT-1:0] fire_entry_out,
   output logic              alloc_valid_out,
   output logic [RS_BIT-1:0] alloc_entry_out,
   output logic              full_out,
   output logic [RS_BIT:0]   free_cnt_out
);

   localparam logic [RS_SIZE-1:0] ONE = {{(RS_SIZE-1){1'b0}}, 1'b1};

   function automatic logic [RS_BIT:0] popcount(input logic [RS_SIZE-1:0] v);
      logic [RS_BIT:0] cnt;
      cnt = '0;
      for (int i = 0; i < RS_SIZE; i++)
         cnt = cnt + {{RS_BIT{1'b0}}, v[i]};
      return cnt;
   endfunction

   issue_state_t       state_q, state_d;
   logic [RS_BIT-1:0]  rr_ptr, rr_d;
   logic [RS_SIZE-1:0] issued_mask, issued_d;
   logic [RS_SIZE-1:0] alloc_mask, alloc_mask_d;
   logic               fire_valid_d;
   logic [RS_BIT-1:0]  fire_entry_d;

   logic [RS_SIZE-1:0] fire_oh, eligible, free_set;
   logic [RS_BIT-1:0]  issue_base, iss_idx, alloc_idx;
   logic               iss_found, alloc_found, alloc_take;

   // The presented entry and the one just accepted stay out of selection until the RS updates them.
   assign fire_oh    = fire_valid_out ? (ONE << fire_entry_out) : '0;
   assign eligible   = busy_in & prepared_in & ~issued_mask & ~fire_oh;
   assign issue_base = (RR_MODE != 0) ? rr_ptr : '0;
   assign alloc_take = alloc_req_in && alloc_valid_out && !clear_in;

   always_comb begin
      free_set = ~busy_in;
      if (!clear_in) begin
         free_set = free_set & ~alloc_mask;
         if (alloc_take)
            free_set = free_set & ~(ONE << alloc_entry_out);
      end
   end

   rs_prio_pick #(.N(RS_SIZE), .W(RS_BIT)) u_issue_pick (
      .req   (eligible),
      .base  (issue_base),
      .found (iss_found),
      .idx   (iss_idx)
   );

   rs_prio_pick #(.N(RS_SIZE), .W(RS_BIT)) u_alloc_pick (
      .req   (free_set),
      .base  ('0),
      .found (alloc_found),
      .idx   (alloc_idx)
   );

   always_comb begin
      state_d      = state_q;
      fire_valid_d = fire_valid_out;
      fire_entry_d = fire_entry_out;
      rr_d         = rr_ptr;
      issued_d     = '0;
      alloc_mask_d = '0;
      if (clear_in) begin
         state_d      = IDLE;
         fire_valid_d = 1'b0;
         rr_d         = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (iss_found) begin
                  state_d      = HOLD;
                  fire_valid_d = 1'b1;
                  fire_entry_d = iss_idx;
               end
            end
            HOLD: begin
               if (exe_ready_in) begin
                  issued_d = ONE << fire_entry_out;
                  if (RR_MODE != 0)
                     rr_d = fire_entry_out + RS_BIT'(1);
                  if (iss_found) begin
                     fire_entry_d = iss_idx;
                  end else begin
                     state_d      = IDLE;
                     fire_valid_d = 1'b0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
         if (alloc_take)
            alloc_mask_d = ONE << alloc_entry_out;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q         <= IDLE;
         fire_valid_out  <= 1'b0;
         fire_entry_out  <= '0;
         alloc_valid_out <= 1'b0;
         alloc_entry_out <= '0;
         free_cnt_out    <= '0;
         rr_ptr          <= '0;
         issued_mask     <= '0;
         alloc_mask      <= '0;
      end else if (rdy_in) begin
         state_q         <= state_d;
         fire_valid_out  <= fire_valid_d;
         fire_entry_out  <= fire_entry_d;
         alloc_valid_out <= alloc_found;
         alloc_entry_out <= alloc_idx;
         free_cnt_out    <= popcount(free_set);
         rr_ptr          <= rr_d;
         issued_mask     <= issued_d;
         alloc_mask      <= alloc_mask_d;
      end
   end

   assign full_out = !alloc_valid_out;

endmodule

// File: tb/tb_rs_select_arbiter.sv
module tb_rs_select_arbiter;

   localparam int N  = 16;
   localparam int RR = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        clr = 1'b0;
   logic [15:0] busy = '0;
   logic [15:0] prep = '0;
   logic        exe = 1'b0;
   logic        areq = 1'b0;

   logic        fire_valid, alloc_valid, full;
   logic [3:0]  fire_entry, alloc_entry;
   logic [4:0]  free_cnt;

   int total = 0;
   int bad   = 0;

   rs_select_arbiter #(.RS_SIZE(16), .RS_BIT(4), .RR_MODE(RR)) dut (
      .clk_in          (clk),
      .rst_in          (rst),
      .rdy_in          (rdy),
      .clear_in        (clr),
      .busy_in         (busy),
      .prepared_in     (prep),
      .exe_ready_in    (exe),
      .alloc_req_in    (areq),
      .fire_valid_out  (fire_valid),
      .fire_entry_out  (fire_entry),
      .alloc_valid_out (alloc_valid),
      .alloc_entry_out (alloc_entry),
      .full_out        (full),
      .free_cnt_out    (free_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: entry indices as ints, -1 meaning "none".
   int m_fv, m_fe, m_av, m_ae, m_cnt, m_rr, m_iss, m_amk;

   always @(posedge clk or posedge rst) begin
      int base, pk, j, cons, amk_old, cnt, low, fired;
      if (rst) begin
         m_fv = 0; m_fe = 0; m_av = 0; m_ae = 0; m_cnt = 0;
         m_rr = 0; m_iss = -1; m_amk = -1;
      end else if (rdy) begin
         cons = -1;
         amk_old = -1;
         if (clr) begin
            m_fv = 0; m_rr = 0; m_iss = -1; m_amk = -1;
         end else begin
            fired = (m_fv != 0 && exe) ? 1 : 0;
            base = (RR != 0) ? m_rr : 0;
            pk = -1;
            for (int k = 0; k < N; k++) begin
               j = (base + k) % N;
               if (pk < 0 && busy[j] && prep[j] && j != m_iss && !(m_fv != 0 && j == m_fe))
                  pk = j;
            end
            cons = (areq && m_av != 0) ? m_ae : -1;
            amk_old = m_amk;
            m_iss = fired ? m_fe : -1;
            if (fired && RR != 0) m_rr = (m_fe + 1) % N;
            if (m_fv == 0 || fired) begin
               if (pk >= 0) begin
                  m_fv = 1;
                  m_fe = pk;
               end else begin
                  m_fv = 0;
               end
            end
            m_amk = cons;
         end
         cnt = 0;
         low = -1;
         for (int i = 0; i < N; i++) begin
            if (!busy[i] && i != amk_old && i != cons) begin
               cnt++;
               if (low < 0) low = i;
            end
         end
         m_cnt = cnt;
         m_av = (cnt > 0) ? 1 : 0;
         m_ae = (low >= 0) ? low : 0;
      end
   end

   always @(negedge clk) begin
      chk("fire_valid", int'(fire_valid), m_fv);
      chk("alloc_valid", int'(alloc_valid), m_av);
      chk("full", int'(full), (m_av != 0) ? 0 : 1);
      chk("free_cnt", int'(free_cnt), m_cnt);
      if (m_fv != 0) chk("fire_entry", int'(fire_entry), m_fe);
      if (m_av != 0) chk("alloc_entry", int'(alloc_entry), m_ae);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      tick(); tick();
      chk("rst_fire_valid", int'(fire_valid), 0);
      chk("rst_fire_entry", int'(fire_entry), 0);
      chk("rst_alloc_valid", int'(alloc_valid), 0);
      chk("rst_full", int'(full), 1);
      chk("rst_free_cnt", int'(free_cnt), 0);
      rst = 1'b0;
      tick();
      chk("idle_fire_valid", int'(fire_valid), 0);
      chk("idle_alloc_entry", int'(alloc_entry), 0);
      chk("idle_free_cnt", int'(free_cnt), 16);
      chk("idle_full", int'(full), 0);

      // Round-robin issue with wrap: 0, 8, 15, 0.
      busy = 16'h8101; prep = 16'h8101; exe = 1'b1;
      tick(); chk("rr_seq0", int'(fire_entry), 0); chk("rr_seq0_v", int'(fire_valid), 1);
      tick(); chk("rr_seq1", int'(fire_entry), 8);
      tick(); chk("rr_seq2", int'(fire_entry), 15);
      tick(); chk("rr_seq3", int'(fire_entry), 0);

      // Backpressure holds the pick.
      clr = 1'b1; exe = 1'b0;
      tick(); chk("clr_fire_valid", int'(fire_valid), 0);
      clr = 1'b0;
      tick(); chk("bp_first", int'(fire_entry), 0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("bp_hold_entry", int'(fire_entry), 0);
         chk("bp_hold_valid", int'(fire_valid), 1);
      end
      exe = 1'b1;
      tick(); chk("bp_release", int'(fire_entry), 8);
      exe = 1'b0;

      // Last free slot consumed, then a request while full is dropped.
      clr = 1'b1; busy = 16'hFFFE; prep = 16'h0000;
      tick(); clr = 1'b0;
      chk("one_free_valid", int'(alloc_valid), 1);
      chk("one_free_entry", int'(alloc_entry), 0);
      chk("one_free_cnt", int'(free_cnt), 1);
      areq = 1'b1;
      tick(); chk("consumed_full", int'(full), 1); chk("consumed_cnt", int'(free_cnt), 0);
      tick(); chk("full_req_full", int'(full), 1);
      areq = 1'b0;
      tick();
      chk("full_req_ignored_v", int'(alloc_valid), 1);
      chk("full_req_ignored_e", int'(alloc_entry), 0);
      chk("full_req_ignored_c", int'(free_cnt), 1);

      // Clear beats a simultaneous fire and resets the rotation pointer.
      busy = 16'h0002; prep = 16'h0002; exe = 1'b1;
      tick(); tick();
      chk("single_done", int'(fire_valid), 0);
      busy = 16'h0021; prep = 16'h0021; exe = 1'b0;
      tick(); chk("rr_after_1", int'(fire_entry), 5);
      exe = 1'b1; clr = 1'b1;
      tick(); chk("clr_fire_drop", int'(fire_valid), 0);
      clr = 1'b0; exe = 1'b0;
      tick(); chk("clr_rr_zero", int'(fire_entry), 0);

      // Global stall freezes both handshakes.
      clr = 1'b1;
      tick(); clr = 1'b0;
      busy = 16'h0008; prep = 16'h0008;
      tick();
      chk("stall_pre_fe", int'(fire_entry), 3);
      chk("stall_pre_ae", int'(alloc_entry), 0);
      chk("stall_pre_cnt", int'(free_cnt), 15);
      rdy = 1'b0; exe = 1'b1; areq = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("stall_fe", int'(fire_entry), 3);
         chk("stall_fv", int'(fire_valid), 1);
         chk("stall_ae", int'(alloc_entry), 0);
         chk("stall_cnt", int'(free_cnt), 15);
      end
      rdy = 1'b1;
      tick();
      chk("resume_fv", int'(fire_valid), 0);
      chk("resume_ae", int'(alloc_entry), 1);
      chk("resume_cnt", int'(free_cnt), 14);
      exe = 1'b0; areq = 1'b0;

      // Asynchronous reset aborts a pending issue without a clock edge.
      tick(); tick();
      chk("pre_rst_hold", int'(fire_entry), 3);
      rst = 1'b1;
      #1;
      chk("arst_fire_valid", int'(fire_valid), 0);
      chk("arst_fire_entry", int'(fire_entry), 0);
      chk("arst_full", int'(full), 1);
      #10;
      rst = 1'b0;
      tick(); tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
